// File: rtl/io_port_pkg.sv
// Shared types and opcode field definitions for the IO port transaction unit.
package io_port_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    WRITEBACK = 2'd3
  } io_state_t;

  localparam int OP_LOAD_BIT   = 3;
  localparam int OP_STATUS_BIT = 2;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  localparam int STATUS_TIMEOUT_BIT = 0;

  function automatic logic is_status_load(input logic [3:0] op);
    return op[OP_LOAD_BIT] & op[OP_STATUS_BIT];
  endfunction

endpackage

// File: rtl/io_load_data_alignment.sv
// Selects the addressed data word from a device response, shifts the element
// down to bit 0 and zero-extends it according to the access size.
module io_load_data_alignment
  import io_port_pkg::*;
#(
  parameter int DATABITWIDTH  = 16,
  parameter int PORTBYTEWIDTH = 8,
  parameter int LANEBITWIDTH  = (PORTBYTEWIDTH > 1) ? $clog2(PORTBYTEWIDTH) : 1
) (
  input  logic [LANEBITWIDTH-1:0]    lane,
  input  logic [1:0]                 size,
  input  logic [PORTBYTEWIDTH*8-1:0] port_data,
  output logic [DATABITWIDTH-1:0]    data
);

  localparam int WORD_BYTES = DATABITWIDTH / 8;
  localparam logic [LANEBITWIDTH-1:0] OFFSET_MASK = LANEBITWIDTH'(WORD_BYTES - 1);

  logic [LANEBITWIDTH-1:0] word_base;
  logic [LANEBITWIDTH-1:0] byte_off;
  logic [DATABITWIDTH-1:0] word;
  logic [DATABITWIDTH-1:0] shifted;
  logic [63:0]             size_mask;

  // Upper lane bits pick the word, lower lane bits the byte within it.
  assign word_base = lane & ~OFFSET_MASK;
  assign byte_off  = lane & OFFSET_MASK;
  assign word      = DATABITWIDTH'(port_data >> {word_base, 3'b000});
  assign shifted   = word >> {byte_off, 3'b000};

  always_comb begin
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size)
      SIZE_BYTE:  size_mask = 64'h0000_0000_0000_00FF;
      SIZE_HALF:  size_mask = 64'h0000_0000_0000_FFFF;
      SIZE_WORD:  size_mask = 64'h0000_0000_FFFF_FFFF;
      SIZE_DWORD: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default:    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // Truncating the mask clamps sizes wider than the data word.
  assign data = shifted & DATABITWIDTH'(size_mask);

endmodule

// File: rtl/io_port_transaction_unit.sv
// Runs one buffered IO command at a time on the device port: issue, wait for
// the load response with timeout, then write the result back to the register file.
module io_port_transaction_unit
  import io_port_pkg::*;
#(
  parameter int DATABITWIDTH    = 16,
  parameter int PORTBYTEWIDTH   = 8,
  parameter int REGADDRBITWIDTH = 4,
  parameter int TIMEOUTCYCLES   = 255,
  parameter int TIMEOUTBITWIDTH = $clog2(TIMEOUTCYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       async_rst,
  input  logic                       clk_en,
  input  logic                       CommandInACK,
  output logic                       CommandInREQ,
  input  logic [3:0]                 MinorOpcodeIn,
  input  logic [REGADDRBITWIDTH-1:0] RegisterDestIn,
  input  logic [DATABITWIDTH-1:0]    DataAddrIn,
  input  logic [PORTBYTEWIDTH*8-1:0] DataIn,
  output logic                       PortCmdACK,
  input  logic                       PortCmdREQ,
  output logic [3:0]                 PortOpcode,
  output logic [DATABITWIDTH-1:0]    PortAddr,
  output logic [PORTBYTEWIDTH*8-1:0] PortData,
  input  logic                       PortRespACK,
  output logic                       PortRespREQ,
  input  logic [PORTBYTEWIDTH*8-1:0] PortRespData,
  output logic                       PortAbort,
  output logic                       WritebackACK,
  input  logic                       WritebackREQ,
  output logic [REGADDRBITWIDTH-1:0] WritebackDest,
  output logic [DATABITWIDTH-1:0]    WritebackData,
  output logic                       TimeoutFlag
);

  localparam int LANEBITWIDTH = (PORTBYTEWIDTH > 1) ? $clog2(PORTBYTEWIDTH) : 1;
  localparam logic [TIMEOUTBITWIDTH-1:0] TIMER_LAST = TIMEOUTBITWIDTH'(TIMEOUTCYCLES - 1);

  io_state_t state_q, state_d;

  logic [3:0]                 opcode_q;
  logic [REGADDRBITWIDTH-1:0] dest_q;
  logic [DATABITWIDTH-1:0]    addr_q;
  logic [PORTBYTEWIDTH*8-1:0] data_q;
  logic [DATABITWIDTH-1:0]    wb_data_q;
  logic [TIMEOUTBITWIDTH-1:0] timer_q;
  logic                       timeout_flag_q;
  logic                       abort_q;
  logic [DATABITWIDTH-1:0]    aligned_data;

  logic cmd_fire, port_cmd_fire, resp_fire, wb_fire, timeout_fire;

  assign CommandInREQ  = (state_q == IDLE);
  assign PortCmdACK    = (state_q == ISSUE);
  assign PortRespREQ   = (state_q == WAIT_RESP);
  assign WritebackACK  = (state_q == WRITEBACK);
  assign PortOpcode    = opcode_q;
  assign PortAddr      = addr_q;
  assign PortData      = data_q;
  assign PortAbort     = abort_q;
  assign WritebackDest = dest_q;
  assign WritebackData = wb_data_q;
  assign TimeoutFlag   = timeout_flag_q;

  assign cmd_fire      = CommandInACK & CommandInREQ & clk_en;
  assign port_cmd_fire = PortCmdACK & PortCmdREQ & clk_en;
  assign resp_fire     = PortRespACK & PortRespREQ & clk_en;
  assign wb_fire       = WritebackACK & WritebackREQ & clk_en;
  // A response arriving on the last allowed cycle beats the timeout.
  assign timeout_fire  = PortRespREQ & clk_en & ~PortRespACK & (timer_q == TIMER_LAST);

  io_load_data_alignment #(
    .DATABITWIDTH (DATABITWIDTH),
    .PORTBYTEWIDTH(PORTBYTEWIDTH),
    .LANEBITWIDTH (LANEBITWIDTH)
  ) u_align (
    .lane     (addr_q[LANEBITWIDTH-1:0]),
    .size     (opcode_q[1:0]),
    .port_data(PortRespData),
    .data     (aligned_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_fire) state_d = is_status_load(MinorOpcodeIn) ? WRITEBACK : ISSUE;
      ISSUE:     if (port_cmd_fire) state_d = opcode_q[OP_LOAD_BIT] ? WAIT_RESP : IDLE;
      WAIT_RESP: if (resp_fire || timeout_fire) state_d = WRITEBACK;
      WRITEBACK: if (wb_fire) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q        <= IDLE;
      opcode_q       <= '0;
      dest_q         <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      wb_data_q      <= '0;
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      abort_q <= timeout_fire;
      if (clk_en) begin
        state_q <= state_d;
        case (state_q)
          IDLE: begin
            if (cmd_fire) begin
              opcode_q <= MinorOpcodeIn;
              dest_q   <= RegisterDestIn;
              addr_q   <= DataAddrIn;
              data_q   <= DataIn;
              if (is_status_load(MinorOpcodeIn)) begin
                wb_data_q                     <= '0;
                wb_data_q[STATUS_TIMEOUT_BIT] <= timeout_flag_q;
              end
            end
          end
          ISSUE: if (port_cmd_fire) timer_q <= '0;
          WAIT_RESP: begin
            if (resp_fire)         wb_data_q <= aligned_data;
            else if (timeout_fire) wb_data_q <= '1;
            else                   timer_q   <= timer_q + 1'b1;
          end
          default: ;
        endcase
        if (timeout_fire)
          timeout_flag_q <= 1'b1;
        else if (wb_fire && is_status_load(opcode_q))
          timeout_flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_transaction_unit.sv
// Randomized transaction-level bench for io_port_transaction_unit with a
// byte-array reference model for load alignment and a timeout-flag model.
module tb_io_port_transaction_unit;

  localparam int DW = 16;
  localparam int PB = 8;
  localparam int RW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          async_rst;
  logic          clk_en;
  logic          CommandInACK;
  logic          CommandInREQ;
  logic [3:0]    MinorOpcodeIn;
  logic [RW-1:0] RegisterDestIn;
  logic [DW-1:0] DataAddrIn;
  logic [63:0]   DataIn;
  logic          PortCmdACK;
  logic          PortCmdREQ;
  logic [3:0]    PortOpcode;
  logic [DW-1:0] PortAddr;
  logic [63:0]   PortData;
  logic          PortRespACK;
  logic          PortRespREQ;
  logic [63:0]   PortRespData;
  logic          PortAbort;
  logic          WritebackACK;
  logic          WritebackREQ;
  logic [RW-1:0] WritebackDest;
  logic [DW-1:0] WritebackData;
  logic          TimeoutFlag;

  int checks = 0;
  int errors = 0;
  bit flag_model = 1'b0;

  always #5 clk = ~clk;

  io_port_transaction_unit #(
    .DATABITWIDTH   (DW),
    .PORTBYTEWIDTH  (PB),
    .REGADDRBITWIDTH(RW),
    .TIMEOUTCYCLES  (TO)
  ) dut (
    .clk           (clk),
    .async_rst     (async_rst),
    .clk_en        (clk_en),
    .CommandInACK  (CommandInACK),
    .CommandInREQ  (CommandInREQ),
    .MinorOpcodeIn (MinorOpcodeIn),
    .RegisterDestIn(RegisterDestIn),
    .DataAddrIn    (DataAddrIn),
    .DataIn        (DataIn),
    .PortCmdACK    (PortCmdACK),
    .PortCmdREQ    (PortCmdREQ),
    .PortOpcode    (PortOpcode),
    .PortAddr      (PortAddr),
    .PortData      (PortData),
    .PortRespACK   (PortRespACK),
    .PortRespREQ   (PortRespREQ),
    .PortRespData  (PortRespData),
    .PortAbort     (PortAbort),
    .WritebackACK  (WritebackACK),
    .WritebackREQ  (WritebackREQ),
    .WritebackDest (WritebackDest),
    .WritebackData (WritebackData),
    .TimeoutFlag   (TimeoutFlag)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load result from a byte view of the port: locate the data word holding
  // the addressed byte, take size bytes from there without crossing the word.
  function automatic logic [DW-1:0] ref_align(input logic [15:0] addr, input logic [1:0] size,
                                              input logic [63:0] resp);
    int wbytes = DW / 8;
    int lane   = int'(addr) % PB;
    int off    = lane % wbytes;
    int start  = lane - off;
    int n      = 1 << size;
    logic [DW-1:0] r = '0;
    if (n > wbytes) n = wbytes;
    for (int j = 0; j < n; j++)
      if (off + j < wbytes) r[8*j +: 8] = resp[8*(start+off+j) +: 8];
    return r;
  endfunction

  function automatic logic pick_en(input bit rand_en);
    return rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic run_txn(input logic [3:0] op, input logic [RW-1:0] dest, input logic [15:0] addr,
                         input logic [63:0] data, input int lat, input logic [63:0] resp,
                         input bit rand_en);
    bit fired;
    int guard;
    int k;
    bit timed_out;
    logic [DW-1:0] exp_wb;

    CommandInACK   = 1'b1;
    MinorOpcodeIn  = op;
    RegisterDestIn = dest;
    DataAddrIn     = addr;
    DataIn         = data;
    fired = 1'b0;
    guard = 0;
    while (!fired) begin
      clk_en = pick_en(rand_en);
      fired  = CommandInREQ && clk_en;
      tick();
      guard++;
      if (!fired && guard > 20) begin
        check_val("accept_bound", 0, 1);
        CommandInACK = 1'b0;
        clk_en = 1'b1;
        return;
      end
    end
    CommandInACK   = 1'b0;
    MinorOpcodeIn  = 4'($urandom);
    RegisterDestIn = RW'($urandom);
    DataAddrIn     = DW'($urandom);
    DataIn         = {$urandom, $urandom};
    clk_en         = 1'b1;

    if (op[3] && op[2]) begin
      check_val("status_wb_ack", WritebackACK, 1);
      check_val("status_no_port_cmd", PortCmdACK, 0);
      exp_wb = DW'(flag_model);
    end else begin
      check_val("port_cmd_ack", PortCmdACK, 1);
      check_val("port_opcode", PortOpcode, op);
      check_val("port_addr", PortAddr, addr);
      check_val("port_data", PortData, data);
      repeat ($urandom_range(0, 2)) begin
        PortCmdREQ = 1'b0;
        clk_en     = pick_en(rand_en);
        tick();
        check_val("port_cmd_hold", PortCmdACK, 1);
      end
      PortCmdREQ = 1'b1;
      fired = 1'b0;
      guard = 0;
      while (!fired) begin
        clk_en = pick_en(rand_en);
        fired  = PortCmdACK && clk_en;
        tick();
        guard++;
        if (!fired && guard > 20) begin
          check_val("port_cmd_bound", 0, 1);
          PortCmdREQ = 1'b0;
          clk_en = 1'b1;
          return;
        end
      end
      PortCmdREQ = 1'b0;
      clk_en     = 1'b1;
      if (!op[3]) begin
        check_val("store_cmd_req_back", CommandInREQ, 1);
        check_val("store_no_wb", WritebackACK, 0);
        check_val("store_no_resp_req", PortRespREQ, 0);
        return;
      end
      check_val("resp_req", PortRespREQ, 1);
      k = 0;
      guard = 0;
      fired = 1'b0;
      while (!fired && k < TO) begin
        clk_en       = pick_en(rand_en);
        PortRespACK  = (k == lat);
        PortRespData = (k == lat) ? resp : {$urandom, $urandom};
        tick();
        if (clk_en) begin
          fired = (k == lat);
          k++;
        end
        if (!fired && k < TO) begin
          check_val("no_early_abort", PortAbort, 0);
          check_val("resp_req_held", PortRespREQ, 1);
        end
        guard++;
        if (guard > 200) begin
          check_val("resp_bound", 0, 1);
          PortRespACK = 1'b0;
          clk_en = 1'b1;
          return;
        end
      end
      PortRespACK  = 1'b0;
      PortRespData = {$urandom, $urandom};
      clk_en       = 1'b1;
      timed_out    = !fired;
      check_val("abort_pulse", PortAbort, timed_out);
      if (timed_out) begin
        exp_wb     = '1;
        flag_model = 1'b1;
      end else begin
        exp_wb = ref_align(addr, op[1:0], resp);
      end
      check_val("timeout_flag_after_load", TimeoutFlag, flag_model);
      check_val("load_wb_ack", WritebackACK, 1);
    end

    check_val("wb_data", WritebackData, exp_wb);
    check_val("wb_dest", WritebackDest, dest);
    repeat ($urandom_range(0, 3)) begin
      if (rand_en && $urandom_range(0, 1) == 1) begin
        WritebackREQ = 1'b1;
        clk_en       = 1'b0;
      end else begin
        WritebackREQ = 1'b0;
        clk_en       = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      check_val("wb_hold_ack", WritebackACK, 1);
      check_val("wb_hold_data", WritebackData, exp_wb);
      check_val("abort_one_cycle", PortAbort, 0);
    end
    WritebackREQ = 1'b1;
    clk_en       = 1'b1;
    tick();
    WritebackREQ = 1'b0;
    if (op[3] && op[2]) flag_model = 1'b0;
    check_val("wb_done_cmd_req", CommandInREQ, 1);
    check_val("wb_done_ack_low", WritebackACK, 0);
    check_val("wb_done_abort_low", PortAbort, 0);
    check_val("timeout_flag", TimeoutFlag, flag_model);
  endtask

  initial begin
    async_rst      = 1'b1;
    clk_en         = 1'b1;
    CommandInACK   = 1'b0;
    MinorOpcodeIn  = '0;
    RegisterDestIn = '0;
    DataAddrIn     = '0;
    DataIn         = '0;
    PortCmdREQ     = 1'b0;
    PortRespACK    = 1'b0;
    PortRespData   = '0;
    WritebackREQ   = 1'b0;
    repeat (3) @(posedge clk);
    #1 async_rst = 1'b0;
    tick();
    check_val("rst_cmd_req", CommandInREQ, 1);
    check_val("rst_port_cmd_ack", PortCmdACK, 0);
    check_val("rst_resp_req", PortRespREQ, 0);
    check_val("rst_abort", PortAbort, 0);
    check_val("rst_wb_ack", WritebackACK, 0);
    check_val("rst_flag", TimeoutFlag, 0);

    run_txn(4'b0001, 4'd2, 16'h0004, 64'h1122_3344_5566_7788, 0, '0, 1'b0);
    run_txn(4'b1000, 4'd9, 16'h0005, 64'h0, 2, 64'h0000_AB00_0000_0000, 1'b0);
    run_txn(4'b1001, 4'd3, 16'h0002, 64'h0, TO + 4, '0, 1'b0);

    // Reset while waiting on a response; the flag set above must clear too.
    CommandInACK   = 1'b1;
    MinorOpcodeIn  = 4'b1001;
    RegisterDestIn = 4'd7;
    DataAddrIn     = 16'h0010;
    tick();
    CommandInACK = 1'b0;
    PortCmdREQ   = 1'b1;
    tick();
    PortCmdREQ = 1'b0;
    tick();
    tick();
    check_val("pre_rst_resp_req", PortRespREQ, 1);
    check_val("pre_rst_flag", TimeoutFlag, 1);
    #2 async_rst = 1'b1;
    #1;
    check_val("midrst_cmd_req", CommandInREQ, 1);
    check_val("midrst_resp_req", PortRespREQ, 0);
    check_val("midrst_flag", TimeoutFlag, 0);
    check_val("midrst_abort", PortAbort, 0);
    check_val("midrst_wb_ack", WritebackACK, 0);
    tick();
    async_rst  = 1'b0;
    flag_model = 1'b0;
    tick();
    check_val("postrst_abort", PortAbort, 0);

    run_txn(4'b1010, 4'd4, 16'h0006, 64'h0, TO + 1, '0, 1'b0);
    run_txn(4'b1100, 4'd5, 16'h0000, 64'h0, 0, '0, 1'b0);
    run_txn(4'b1101, 4'd6, 16'h0000, 64'h0, 0, '0, 1'b1);
    run_txn(4'b1011, 4'd1, 16'h0003, 64'h0, TO - 1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    run_txn(4'b1001, 4'd8, 16'h0007, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 1'b1);

    for (int i = 0; i < 200; i++) begin
      run_txn(4'($urandom), RW'($urandom), 16'($urandom), {$urandom, $urandom},
              $urandom_range(0, TO + 1), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_transaction_unit.md
Name: io_port_transaction_unit

Overview:
- Sits directly downstream of the IO command interface and consumes its buffered command: opcode, destination register, address and full-port store data.
- Runs exactly one transaction at a time on the external device port: issue, then response wait with timeout for loads, then register writeback.
- Load data is aligned and zero-extended to DATABITWIDTH before writeback.
- Status loads are answered locally and never reach the device port.

Parameters:
DATABITWIDTH, 16, register/data word width (8/16/32/64)
PORTBYTEWIDTH, 8, device port width in bytes
REGADDRBITWIDTH, 4, register destination index width
TIMEOUTCYCLES, 255, WAIT_RESP cycles before abort (>=2)
TIMEOUTBITWIDTH, $clog2(TIMEOUTCYCLES+1), timer width (derived)

Ports:
clk  in  1  clock
async_rst  in  1  asynchronous active-high reset
clk_en  in  1  global enable; gates every state and register update
CommandInACK  in  1  upstream command valid
CommandInREQ  out  1  ready to accept a command
MinorOpcodeIn  in  4  [3]=load, [2]=status (when load), [1:0]=size (byte/half/word/dword)
RegisterDestIn  in  REGADDRBITWIDTH  writeback destination
DataAddrIn  in  DATABITWIDTH  element address
DataIn  in  PORTBYTEWIDTH*8  store data
PortCmdACK  out  1  device command valid
PortCmdREQ  in  1  device command ready
PortOpcode  out  4  captured opcode
PortAddr  out  DATABITWIDTH  captured address
PortData  out  PORTBYTEWIDTH*8  captured store data
PortRespACK  in  1  device response valid
PortRespREQ  out  1  ready for response
PortRespData  in  PORTBYTEWIDTH*8  response data
PortAbort  out  1  one-cycle pulse on timeout; device discards the pending response
WritebackACK  out  1  writeback valid
WritebackREQ  in  1  register file ready
WritebackDest  out  REGADDRBITWIDTH  destination register
WritebackData  out  DATABITWIDTH  load result
TimeoutFlag  out  1  sticky timeout indicator

Behaviour:
- Handshake fires when ACK && REQ && clk_en. Nothing advances while clk_en=0.
- Reset (async_rst): state=IDLE; all capture registers, timer and TimeoutFlag cleared.
  - Outputs after reset: CommandInREQ=1; PortCmdACK=0; PortRespREQ=0; PortAbort=0; WritebackACK=0.
  - Reset mid-transaction abandons the transaction without any pulse.
- States: IDLE, ISSUE, WAIT_RESP, WRITEBACK. Registered outputs decode from state only:
  - CommandInREQ = IDLE
  - PortCmdACK = ISSUE
  - PortRespREQ = WAIT_RESP
  - WritebackACK = WRITEBACK
- IDLE:
  - On command handshake, capture opcode, dest, addr and data.
  - Opcode[3:2]=11 (status load) -> WRITEBACK with WritebackData = {0..., TimeoutFlag}.
  - Otherwise -> ISSUE.
- ISSUE: on PortCmdREQ, store (opcode[3]=0) -> IDLE; load -> WAIT_RESP with timer=0.
- WAIT_RESP:
  - On PortRespACK: latch the aligned response -> WRITEBACK.
  - Otherwise timer+1. When timer reaches TIMEOUTCYCLES-1 with no response: WritebackData = all ones, set TimeoutFlag, pulse PortAbort one cycle -> WRITEBACK.
  - Response and timeout in the same cycle: the response wins; no abort, no flag.
- WRITEBACK: hold dest/data stable until WritebackREQ -> IDLE.
- Status writeback handshake clears TimeoutFlag in that cycle. A timeout that sets the flag has priority over a clear.
- Alignment of response data:
  - Word index = DataAddr[$clog2(DATABITWIDTH/8)+$clog2(words)-1 : $clog2(DATABITWIDTH/8)].
  - Byte offset = address low bits. Size from opcode[1:0].
  - Result is zero-extended. Sizes wider than DATABITWIDTH are clamped to DATABITWIDTH.
- Latency and throughput:
  - Command accepted at edge N -> PortCmdACK high in cycle N+1.
  - Minimum load: accept to WritebackACK in 3 cycles. Store: 2 cycles back to CommandInREQ.
  - Status load: WritebackACK at N+1.
  - No overlap: throughput is one transaction per completion.

Decomposition:
- Package io_port_pkg: state enum typedef (IDLE/ISSUE/WAIT_RESP/WRITEBACK), opcode field positions, size encodings, status-bit index.
- Sub-module io_load_data_alignment (combinational): word select, byte shift and zero-extend.

Test Plan:
1. Reset mid-WAIT_RESP -> next cycle CommandInREQ=1, PortRespREQ=0, TimeoutFlag=0.
2. Store: op=0001, addr=0x0004, DataIn=0x1122334455667788 -> PortCmdACK next cycle with matching PortAddr/PortData; CommandInREQ returns the cycle after PortCmdREQ; no writeback.
3. Byte load: op=1000, addr=0x0005, PortRespData=0x0000AB0000000000 after 3 cycles (DATABITWIDTH=16) -> WritebackData=0x00AB, dest as sent.
4. Load with no response, TIMEOUTCYCLES=8 -> PortAbort pulse after 8 WAIT_RESP cycles, WritebackData=0xFFFF, TimeoutFlag=1.
5. Status load (op=1100) after test 4 -> WritebackData=0x0001 one cycle after accept, PortCmdACK never asserted, TimeoutFlag=0 after the handshake.
6. Response on the exact timeout cycle plus clk_en toggling in WRITEBACK -> response data written, no abort, WritebackACK held until WritebackREQ with clk_en=1.
